// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB per opcode class
// and emits the datapath control word, commit count and sticky illegal flag.
module cpu_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic        run,
   input  logic        step,
   input  logic        mem_ready,
   output logic [5:0]  ctrlWord,
   output logic [2:0]  state,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_RALU, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_HALT, C_ILL
   } cls_t;

   function automatic cls_t classify(input logic [5:0] op);
      cls_t c;
      if (op[5:4] == 2'b00)        c = C_RALU;
      else if (op[5:4] == 2'b01)   c = C_IALU;
      else if (op == 6'b111111)    c = C_HALT;
      else if (op[5:4] == 2'b11)   c = C_BRANCH;
      else if (op == 6'b100000)    c = C_LOAD;
      else if (op == 6'b100001)    c = C_STORE;
      else                         c = C_ILL;
      return c;
   endfunction

   state_t      state_q;
   logic [5:0]  op_q;
   logic        illegal_q;
   logic [15:0] instret_q;

   cls_t cls_q;
   logic commit;
   logic in_x;

   // Everything after DECODE keys off the latched opcode, never the live bus.
   assign cls_q = classify(op_q);

   always_comb begin
      commit = 1'b0;
      case (state_q)
         S_EXEC:  commit = (cls_q == C_BRANCH) || (cls_q == C_ILL);
         S_MEM:   commit = mem_ready && (cls_q == C_STORE);
         S_WB:    commit = 1'b1;
         default: commit = 1'b0;
      endcase
   end

   assign in_x = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

   // Control word tracks mem_ready within the MEM cycle, so it is decoded from
   // registered state rather than registered itself.
   always_comb begin
      ctrlWord    = 6'b100000;
      ctrlWord[5] = ~commit;
      ctrlWord[4] = in_x && (cls_q == C_RALU);
      ctrlWord[3] = (state_q == S_WB);
      ctrlWord[2] = in_x && ((cls_q == C_IALU) || (cls_q == C_LOAD) || (cls_q == C_STORE));
      ctrlWord[1] = (state_q == S_MEM) && mem_ready && (cls_q == C_STORE);
      ctrlWord[0] = in_x && (cls_q != C_LOAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         op_q      <= 6'd0;
         illegal_q <= 1'b0;
         instret_q <= 16'd0;
      end else begin
         if (commit) instret_q <= instret_q + 16'd1;
         case (state_q)
            S_FETCH:  if (run || step) state_q <= S_DECODE;
            S_DECODE: begin
               op_q <= opcode;
               if (classify(opcode) == C_ILL) illegal_q <= 1'b1;
               state_q <= (classify(opcode) == C_HALT) ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
               case (cls_q)
                  C_LOAD, C_STORE: state_q <= S_MEM;
                  C_RALU, C_IALU:  state_q <= S_WB;
                  default:         state_q <= S_FETCH;
               endcase
            end
            S_MEM:    if (mem_ready) state_q <= (cls_q == C_LOAD) ? S_WB : S_FETCH;
            S_WB:     state_q <= S_FETCH;
            S_HALTED: state_q <= S_HALTED;
            default:  state_q <= S_FETCH;
         endcase
      end
   end

   assign state   = state_q;
   assign halted  = (state_q == S_HALTED);
   assign illegal = illegal_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus random instruction streams,
// each checked cycle-by-cycle against a per-instruction trace built from class latencies.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic        run, step, mem_ready;
   logic [5:0]  ctrlWord;
   logic [2:0]  state;
   logic        halted, illegal;
   logic [15:0] instret;

   cpu_sequencer dut (
      .clk(clk), .rst(rst), .opcode(opcode), .run(run), .step(step),
      .mem_ready(mem_ready), .ctrlWord(ctrlWord), .state(state),
      .halted(halted), .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_HLT = 5, K_ILL = 6;

   int n_chk = 0;
   int n_bad = 0;
   int exp_cnt = 0;
   bit exp_ill = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int kind(input logic [5:0] op);
      int v = int'(op);
      if (v < 16)       return K_R;
      else if (v < 32)  return K_I;
      else if (v == 32) return K_LD;
      else if (v == 33) return K_ST;
      else if (v == 63) return K_HLT;
      else if (v >= 48) return K_BR;
      else              return K_ILL;
   endfunction

   function automatic logic [5:0] pick_op();
      int k = $urandom_range(0, 19);
      if (k < 4)       return 6'($urandom_range(0, 15));
      else if (k < 8)  return 6'($urandom_range(16, 31));
      else if (k < 11) return 6'd32;
      else if (k < 14) return 6'd33;
      else if (k < 17) return 6'($urandom_range(48, 62));
      else if (k < 18) return 6'd63;
      else             return 6'($urandom_range(34, 47));
   endfunction

   task automatic drive(input logic [5:0] op, input logic r, input logic s, input logic mr);
      opcode = op; run = r; step = s; mem_ready = mr;
   endtask

   // Inputs already applied at posedge+1; sample mid-cycle, then advance one clock.
   task automatic one(input logic [2:0] es, input logic [5:0] ec, input bit cm);
      #2;
      chk("state", 32'(state), 32'(es));
      chk("ctrl", 32'(ctrlWord), 32'(ec));
      chk("halted", 32'(halted), 32'(es == 3'd5));
      chk("illegal", 32'(illegal), 32'(exp_ill));
      chk("instret", 32'(instret), 32'(exp_cnt % 65536));
      @(posedge clk); #1;
      if (cm) exp_cnt++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      exp_cnt = 0; exp_ill = 1'b0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ctrl", 32'(ctrlWord), 32'h20);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_instret", 32'(instret), 32'd0);
      @(posedge clk); #1;
      chk("rst_hold", 32'(state), 32'd0);
      rst = 1'b0;
   endtask

   // One instruction: idle FETCH cycles (step mode only), then the class trace.
   // abort >= 0 asserts reset in that MEM wait cycle instead of finishing.
   task automatic run_instr(input logic [5:0] op, input bit smode, input int idle,
                            input int w, input int abort);
      int  k = kind(op);
      bit  r = (k == K_R);
      bit  a = (k == K_I) || (k == K_LD) || (k == K_ST);
      bit  wr = (k != K_LD);
      bit  cm;
      logic rv = smode ? 1'b0 : 1'b1;
      for (int i = 0; i < idle; i++) begin
         drive(pick_op(), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
         one(3'd0, 6'h20, 1'b0);
      end
      drive(pick_op(), rv, smode ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      one(3'd0, 6'h20, 1'b0);
      drive(op, rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      one(3'd1, 6'h20, 1'b0);
      if (k == K_HLT) begin
         for (int i = 0; i < 4; i++) begin
            drive(pick_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            one(3'd5, 6'h20, 1'b0);
         end
         return;
      end
      if (k == K_ILL) exp_ill = 1'b1;
      cm = (k == K_BR) || (k == K_ILL);
      drive(pick_op(), rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      one(3'd2, {~cm, r, 1'b0, a, 1'b0, wr}, cm);
      if (k == K_LD || k == K_ST) begin
         for (int j = 0; j < w; j++) begin
            drive(pick_op(), rv, 1'($urandom_range(0, 1)), 1'b0);
            if (j == abort) begin
               do_reset();
               return;
            end
            one(3'd3, {1'b1, r, 1'b0, a, 1'b0, wr}, 1'b0);
         end
         cm = (k == K_ST);
         drive(pick_op(), rv, 1'($urandom_range(0, 1)), 1'b1);
         one(3'd3, {~cm, r, 1'b0, a, cm, wr}, cm);
      end
      if (k == K_R || k == K_I || k == K_LD) begin
         drive(pick_op(), rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         one(3'd4, {1'b0, r, 1'b1, a, 1'b0, wr}, 1'b1);
      end
   endtask

   initial begin
      drive(6'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      do_reset();

      // R-ALU free-run: commits in WB, count visible in the following FETCH
      run_instr(6'b000010, 1'b0, 0, 0, -1);
      #2 chk("ralu_instret", 32'(instret), 32'd1);
      #0;
      @(posedge clk); #1;
      // next cycle already decoding since run stayed high; re-sync with a reset
      do_reset();

      run_instr(6'b100000, 1'b0, 0, 2, -1);   // LOAD, two wait cycles
      run_instr(6'b100001, 1'b0, 0, 0, -1);   // STORE, ready at once
      run_instr(6'b110101, 1'b1, 10, 0, -1);  // single step after ten idle cycles
      drive(6'd0, 1'b0, 1'b0, 1'b0);
      one(3'd0, 6'h20, 1'b0);
      run_instr(6'b111111, 1'b0, 0, 0, -1);   // HALT
      do_reset();
      run_instr(6'b101010, 1'b0, 0, 0, -1);   // ILLEGAL executes as NOP
      run_instr(6'b100001, 1'b0, 0, 3, 1);    // reset during a store's MEM wait

      for (int n = 0; n < 250; n++) begin
         logic [5:0] op = pick_op();
         bit sm = 1'($urandom_range(0, 1));
         run_instr(op, sm, sm ? $urandom_range(0, 3) : 0, $urandom_range(0, 3), -1);
         if (kind(op) == K_HLT) do_reset();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
